fp_mult_arbiter: RTL
====================

Name: fp_mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one fp_single_multiplier between NUM_REQ requesters.
- Requesters are the value-iteration units of the MDP datapath.
- Accepts a half-precision (16-bit) operand pair from the granted requester, issues a start pulse to the multiplier and waits for done.
- Returns the product to the granted requester with a one-cycle valid pulse.

Parameters:
- NUM_REQ, 4, number of requesters sharing the multiplier (2..8).
- DATA_W, 16, operand/result width; half-precision format.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT. Used only with FP_MULT_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  NUM_REQ  per-requester request; held high with stable operands until that requester's resp_valid.
- req_a  input  NUM_REQ*DATA_W  packed operand A; requester i at bits [i*DATA_W +: DATA_W].
- req_b  input  NUM_REQ*DATA_W  packed operand B, same packing.
- grant  output  NUM_REQ  one-hot grant; high from ISSUE through RESPOND.
- resp_valid  output  NUM_REQ  one-cycle pulse to the granted requester carrying the result.
- resp_z  output  DATA_W  product; valid only while any resp_valid bit is high.
- mult_start  output  1  one-cycle start pulse to the multiplier.
- mult_a  output  DATA_W  registered operand A to the multiplier.
- mult_b  output  DATA_W  registered operand B to the multiplier.
- mult_z  input  DATA_W  multiplier result.
- mult_done  input  1  multiplier completion pulse.
- busy  output  1  high in any state other than IDLE.
- err  output  1  one-cycle timeout pulse; constant 0 when the feature is compiled out.

Behaviour:
- Reset values (asynchronous, while reset = 0):
  - state = IDLE, rr_ptr = 0.
  - grant, resp_valid, resp_z, mult_start, mult_a, mult_b, busy and err are all 0.
  - A reset mid-operation abandons the transaction; no resp_valid is produced. The multiplier shares the same reset.
- States: IDLE, ISSUE, WAIT, RESPOND (2-bit encoding).
- IDLE, when req != 0:
  - Select g = first set req bit scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Latch req_a[g] into mult_a and req_b[g] into mult_b; set grant = onehot(g).
  - Go to ISSUE.
- IDLE, when req == 0: hold.
- ISSUE: mult_start = 1 for exactly this cycle; go to WAIT.
- WAIT:
  - mult_start = 0.
  - On mult_done = 1: capture mult_z into resp_z and go to RESPOND.
  - mult_done is sampled only in WAIT. A done pulse in IDLE, ISSUE or RESPOND is ignored.
- RESPOND:
  - resp_valid[g] = 1 for one cycle.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - grant cleared on exit; go to IDLE.
- Requester handshake:
  - The requester must drop req in the cycle after resp_valid.
  - req still high in that next IDLE cycle counts as a new request, arbitrated at the lowest priority because of the rr_ptr advance.
- Latency: request sampled in IDLE at cycle 0 → mult_start at cycle 1 → done at cycle 1+L → resp_valid at cycle 2+L, where L ≥ 1 is the multiplier latency. Overhead is 3 cycles per transaction.
- Simultaneous requests: exactly one grant per transaction. Starvation is bounded by NUM_REQ-1 transactions.
- req changes while not granted are permitted. Operands are latched only in IDLE.

Optional Feature:
- Macro: FP_MULT_ARB_TIMEOUT_EN.
- Defined:
  - 8-bit watchdog counter, cleared on entry to WAIT and incremented each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without mult_done: resp_z = 16'h7E00 (qNaN) and err = 1 for one cycle, coincident with resp_valid; then RESPOND proceeds as normal.
- Undefined: no counter is built, WAIT waits indefinitely, and err is tied to 0.

Decomposition:
- Shared package fp_mdp_pkg holds:
  - State encodings ARB_IDLE/ARB_ISSUE/ARB_WAIT/ARB_RESPOND.
  - FP16_W = 16.
  - FP16_QNAN = 16'h7E00.
- One sub-module, rr_priority_pick: combinational rotate-and-find-first that takes req and rr_ptr and returns a one-hot grant plus an index.

Test Plan:
- Single request: req = 4'b0001, a = 16'hBB33 (-0.9), b = 16'h4333 (3.6), bench model latency L = 4 → mult_start at cycle 1, resp_valid[0] at cycle 6, resp_z = 16'hC27B.
- Contention: req = 4'b1111 held, each requester re-asserting after its response → grant order 0, 1, 2, 3, 0, with exactly one resp_valid per transaction.
- Pointer fairness: requester 2 served, then req = 4'b0101 → requester 0 granted before requester 2 again.
- Spurious mult_done in IDLE and during ISSUE → ignored; no resp_valid; state remains IDLE or advances to WAIT normally.
- Reset asserted (reset = 0) during WAIT → all outputs 0 asynchronously; after release, a new request completes normally with rr_ptr = 0.
- With FP_MULT_ARB_TIMEOUT_EN defined and the multiplier model never asserting done → after 64 WAIT cycles: resp_valid and err pulse, resp_z = 16'h7E00, return to IDLE.

Source files
------------

// File: rtl/fp_mdp_pkg.sv
// rtl/fp_mdp_pkg.sv - shared MDP datapath types: arbiter state encoding and fp16 constants
package fp_mdp_pkg;

  localparam int FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_WAIT    = 2'd2,
    ARB_RESPOND = 2'd3
  } arb_state_e;

endpackage

// File: rtl/fp_mult_arbiter_if.sv
// rtl/fp_mult_arbiter_if.sv - requester-side bus of the shared fp16 multiplier arbiter
interface fp_mult_arbiter_if
  import fp_mdp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = FP16_W
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_z;

  modport master (
    output req, req_a, req_b,
    input  grant, resp_valid, resp_z
  );

  modport slave (
    input  req, req_a, req_b,
    output grant, resp_valid, resp_z
  );

endinterface

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotate-and-find-first: first set req bit at or after rr_ptr, modulo NUM_REQ
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  logic [PTR_W-1:0] slot;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_valid  = 1'b0;
    slot       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!gnt_valid && req[slot]) begin
        gnt_valid        = 1'b1;
        gnt_idx          = slot;
        gnt_onehot[slot] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// rtl/fp_mult_arbiter.sv - round-robin sequencer sharing one fp16 multiplier among NUM_REQ requesters
// Optional WAIT watchdog enabled by FP_MULT_ARB_TIMEOUT_EN.
module fp_mult_arbiter
  import fp_mdp_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = FP16_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  fp_mult_arbiter_if.slave  req_bus,
  output logic              mult_start,
  output logic [DATA_W-1:0] mult_a,
  output logic [DATA_W-1:0] mult_b,
  input  logic [DATA_W-1:0] mult_z,
  input  logic              mult_done,
  output logic              busy,
  output logic              err
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fp_mult_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("fp_mult_arbiter: TIMEOUT_CYCLES must fit the 8-bit watchdog");
  end

  arb_state_e         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               timeout_hit;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req        (req_bus.req),
    .rr_ptr     (rr_ptr),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .gnt_valid  (pick_valid)
  );

`ifdef FP_MULT_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt;

  // Counter idles at zero outside WAIT, so it starts from zero on every WAIT entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state != ARB_WAIT) begin
      wd_cnt <= '0;
    end else if (!timeout_hit) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

  assign timeout_hit = (state == ARB_WAIT) && (wd_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= ARB_IDLE;
      rr_ptr             <= '0;
      gnt_idx            <= '0;
      req_bus.grant      <= '0;
      req_bus.resp_valid <= '0;
      req_bus.resp_z     <= '0;
      mult_start         <= 1'b0;
      mult_a             <= '0;
      mult_b             <= '0;
      busy               <= 1'b0;
      err                <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            gnt_idx       <= pick_idx;
            req_bus.grant <= pick_onehot;
            mult_a        <= req_bus.req_a[pick_idx*DATA_W +: DATA_W];
            mult_b        <= req_bus.req_b[pick_idx*DATA_W +: DATA_W];
            mult_start    <= 1'b1;
            busy          <= 1'b1;
            state         <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          mult_start <= 1'b0;
          state      <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // A real result wins over a watchdog expiry landing in the same cycle.
          if (mult_done) begin
            req_bus.resp_z     <= mult_z;
            req_bus.resp_valid <= req_bus.grant;
            state              <= ARB_RESPOND;
          end else if (timeout_hit) begin
            req_bus.resp_z     <= DATA_W'(FP16_QNAN);
            req_bus.resp_valid <= req_bus.grant;
            err                <= 1'b1;
            state              <= ARB_RESPOND;
          end
        end
        ARB_RESPOND: begin
          req_bus.resp_valid <= '0;
          req_bus.grant      <= '0;
          err                <= 1'b0;
          busy               <= 1'b0;
          rr_ptr             <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
          state              <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
